// File: rtl/timer_mode_ctrl.sv
// timer_mode_ctrl: mode/alarm controller for the digital clock.
// Turns two debounced buttons into a six-state mode machine, emits
// increment strobes and a hold to the time counters, owns the alarm
// registers, and drives the blink mask and beeper enable.
module timer_mode_ctrl #(
  parameter int RING_SECS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       hold,
  output logic       hour_inc,
  output logic       min_inc,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       alarm_en,
  output logic [1:0] blink_mask,
  output logic       beep_en,
  output logic [2:0] mode
);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    SET_H = 3'd1,
    SET_M = 3'd2,
    AL_H  = 3'd3,
    AL_M  = 3'd4,
    RING  = 3'd5
  } state_t;

  localparam logic [5:0] RING_LAST = 6'(RING_SECS - 1);

  state_t     state, next_state;
  logic       mode_b_r, mode_b_q, inc_b_r, inc_b_q;
  logic       mode_edge, inc_edge, any_edge;
  logic       match, match_q, ring_start, ring_done;
  logic [5:0] ring_cnt;
  logic       phase;
  logic       hour_inc_d, min_inc_d, al_h_inc, al_m_inc, al_en_tgl;

  // The sync flops reset to 1 so a button held through reset never
  // looks like a fresh press once reset is released.
  assign mode_edge = mode_b_r & ~mode_b_q;
  assign inc_edge  = inc_b_r & ~inc_b_q;
  assign any_edge  = mode_edge | inc_edge;

  assign match = alarm_en && (cur_hour == alarm_hour) &&
                 (cur_min == alarm_min) && (cur_sec == 6'd0);
  // Only a fresh match seen while running starts the alarm; a match that
  // arrives in any other state is dropped rather than retried.
  assign ring_start = (state == RUN) && match && !match_q;
  assign ring_done  = tick_1hz && (ring_cnt == RING_LAST);

  assign mode = state;

  // Button synchronisers and match history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_b_r <= 1'b1;
      mode_b_q <= 1'b1;
      inc_b_r  <= 1'b1;
      inc_b_q  <= 1'b1;
      match_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value
      // of its source, so b_q lags b_r by exactly one cycle.
      mode_b_r <= btn_mode;
      mode_b_q <= mode_b_r;
      inc_b_r  <= btn_inc;
      inc_b_q  <= inc_b_r;
      match_q  <= match;
    end
  end

  // Next-state and strobe decode; a mode edge always wins over an inc edge.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    next_state = state;
    hour_inc_d = 1'b0;
    min_inc_d  = 1'b0;
    al_h_inc   = 1'b0;
    al_m_inc   = 1'b0;
    al_en_tgl  = 1'b0;
    case (state)
      RUN: begin
        if (ring_start)     next_state = RING;
        else if (mode_edge) next_state = SET_H;
        else if (inc_edge)  al_en_tgl  = 1'b1;
      end
      SET_H: begin
        if (mode_edge)     next_state = SET_M;
        else if (inc_edge) hour_inc_d = 1'b1;
      end
      SET_M: begin
        if (mode_edge)     next_state = AL_H;
        else if (inc_edge) min_inc_d  = 1'b1;
      end
      AL_H: begin
        if (mode_edge)     next_state = AL_M;
        else if (inc_edge) al_h_inc   = 1'b1;
      end
      AL_M: begin
        if (mode_edge)     next_state = RUN;
        else if (inc_edge) al_m_inc   = 1'b1;
      end
      RING: begin
        // Any press silences the alarm and is consumed here.
        if (any_edge || ring_done) next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      hold     <= 1'b0;
      hour_inc <= 1'b0;
      min_inc  <= 1'b0;
      beep_en  <= 1'b0;
    end else begin
      state    <= next_state;
      hold     <= (next_state == SET_H) || (next_state == SET_M);
      hour_inc <= hour_inc_d;
      min_inc  <= min_inc_d;
      beep_en  <= (next_state == RING);
    end
  end

  // Alarm registers: hour wraps 23->0, minute wraps 59->0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_hour <= 5'd0;
      alarm_min  <= 6'd0;
      alarm_en   <= 1'b0;
    end else begin
      if (al_h_inc) alarm_hour <= (alarm_hour == 5'd23) ? 5'd0 : alarm_hour + 5'd1;
      if (al_m_inc) alarm_min  <= (alarm_min == 6'd59) ? 6'd0 : alarm_min + 6'd1;
      if (al_en_tgl) alarm_en  <= ~alarm_en;
    end
  end

  // Ring duration counter: held at zero outside RING so entry starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_cnt <= 6'd0;
    end else if (state != RING) begin
      ring_cnt <= 6'd0;
    end else if (tick_1hz) begin
      ring_cnt <= ring_cnt + 6'd1;
    end
  end

  // Blink phase: toggles per second while setting, cleared otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 1'b0;
    end else if (next_state == RUN || next_state == RING) begin
      phase <= 1'b0;
    end else if (tick_1hz && state != RUN && state != RING) begin
      phase <= ~phase;
    end
  end

  // Blink mask selects the field being edited during the blank phase.
  always_comb begin
    blink_mask = 2'b00;
    if (phase) begin
      if (state == SET_H || state == AL_H)      blink_mask = 2'b10;
      else if (state == SET_M || state == AL_M) blink_mask = 2'b01;
    end
  end

endmodule

// File: tb/tb_timer_mode_ctrl.sv
// Directed testbench for timer_mode_ctrl with hand-computed expectations.
module tb_timer_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic       hold;
  logic       hour_inc;
  logic       min_inc;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_en;
  logic [1:0] blink_mask;
  logic       beep_en;
  logic [2:0] mode;

  int checks   = 0;
  int failures = 0;

  timer_mode_ctrl #(.RING_SECS(30)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .hold(hold), .hour_inc(hour_inc), .min_inc(min_inc),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_en(alarm_en),
    .blink_mask(blink_mask), .beep_en(beep_en), .mode(mode)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Press and release buttons; counts the strobes seen over the whole press.
  task automatic press(input bit do_mode, input bit do_inc,
                       output int n_h, output int n_m);
    n_h = 0;
    n_m = 0;
    btn_mode = do_mode;
    btn_inc  = do_inc;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 1) begin
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
      end
      n_h += int'(hour_inc);
      n_m += int'(min_inc);
    end
  endtask

  task automatic tick_pulse();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic test_reset();
    int nh, nm;
    rst = 1'b1; btn_mode = 1'b1; btn_inc = 1'b0; tick_1hz = 1'b0;
    cur_hour = 5'd12; cur_min = 6'd0; cur_sec = 6'd5;
    step(); step();
    checks++;
    if ({mode, hold, hour_inc, min_inc, alarm_hour, alarm_min, alarm_en, blink_mask, beep_en} !== 23'd0) begin
      failures++;
      $display("FAIL reset_values: mode=%0d hold=%0b ah=%0d am=%0d en=%0b blink=%b beep=%0b, want all 0",
               mode, hold, alarm_hour, alarm_min, alarm_en, blink_mask, beep_en);
    end
    rst = 1'b0;
    nh = 0; nm = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      nh += int'(hour_inc); nm += int'(min_inc);
    end
    btn_mode = 1'b0;
    step(); step();
    checks++;
    if (mode !== 3'd0 || nh != 0 || nm != 0) begin
      failures++;
      $display("FAIL held_through_reset: mode=%0d strobes=%0d/%0d, want mode=0 no strobes", mode, nh, nm);
    end
    btn_mode = 1'b1;
    step();
    checks++;
    if (mode !== 3'd0) begin
      failures++;
      $display("FAIL press_latency_1: mode=%0d after one edge, want 0", mode);
    end
    step();
    checks++;
    if (mode !== 3'd1 || hold !== 1'b1) begin
      failures++;
      $display("FAIL press_latency_2: mode=%0d hold=%0b, want mode=1 hold=1", mode, hold);
    end
    btn_mode = 1'b0;
    step(); step();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
  endtask

  task automatic test_mode_cycle();
    logic [2:0] exp_mode [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic       exp_hold [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      btn_mode = 1'b1;
      step(); step();
      checks++;
      if (mode !== exp_mode[i] || hold !== exp_hold[i]) begin
        failures++;
        $display("FAIL mode_cycle[%0d]: mode=%0d hold=%0b, want mode=%0d hold=%0b",
                 i, mode, hold, exp_mode[i], exp_hold[i]);
      end
      btn_mode = 1'b0;
      step(); step();
    end
  endtask

  task automatic test_set_min();
    int nh, nm, th, tm;
    press(1, 0, nh, nm);
    press(1, 0, nh, nm);
    th = 0; tm = 0;
    for (int i = 0; i < 3; i++) begin
      press(0, 1, nh, nm);
      th += nh; tm += nm;
      checks++;
      if (nm != 1) begin
        failures++;
        $display("FAIL min_inc_width[%0d]: %0d cycles high, want 1", i, nm);
      end
    end
    checks++;
    if (tm != 3 || th != 0 || mode !== 3'd2 || hold !== 1'b1) begin
      failures++;
      $display("FAIL set_min: min_inc=%0d hour_inc=%0d mode=%0d hold=%0b, want 3 0 2 1", tm, th, mode, hold);
    end
    press(1, 1, nh, nm);
    checks++;
    if (mode !== 3'd3 || nm != 0 || nh != 0 || alarm_hour !== 5'd0) begin
      failures++;
      $display("FAIL mode_inc_same_cycle: mode=%0d min_inc=%0d ah=%0d, want mode=3 no strobe ah=0", mode, nm, alarm_hour);
    end
  endtask

  task automatic test_blink();
    int nh, nm;
    logic [1:0] exp [8] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    logic [1:0] got [8];
    got[0] = blink_mask;
    tick_pulse();         got[1] = blink_mask;
    press(1, 0, nh, nm);  got[2] = blink_mask;
    tick_pulse();         got[3] = blink_mask;
    tick_pulse();         got[4] = blink_mask;
    press(1, 0, nh, nm);  got[5] = blink_mask;
    press(1, 0, nh, nm);  got[6] = blink_mask;
    tick_pulse();         got[7] = blink_mask;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("FAIL blink[%0d]: mask=%b, want %b", i, got[i], exp[i]);
      end
    end
    press(1, 0, nh, nm);
    press(1, 0, nh, nm);
  endtask

  task automatic test_alarm_wrap();
    int nh, nm, th;
    th = 0;
    for (int i = 0; i < 23; i++) begin
      press(0, 1, nh, nm);
      th += nh;
    end
    checks++;
    if (alarm_hour !== 5'd23 || th != 0) begin
      failures++;
      $display("FAIL alarm_hour_23: ah=%0d hour_inc=%0d, want 23 0", alarm_hour, th);
    end
    press(0, 1, nh, nm);
    checks++;
    if (alarm_hour !== 5'd0) begin
      failures++;
      $display("FAIL alarm_hour_wrap: ah=%0d, want 0", alarm_hour);
    end
    press(1, 0, nh, nm);
    for (int i = 0; i < 59; i++) press(0, 1, nh, nm);
    checks++;
    if (alarm_min !== 6'd59 || mode !== 3'd4) begin
      failures++;
      $display("FAIL alarm_min_59: am=%0d mode=%0d, want 59 4", alarm_min, mode);
    end
    press(0, 1, nh, nm);
    checks++;
    if (alarm_min !== 6'd0) begin
      failures++;
      $display("FAIL alarm_min_wrap: am=%0d, want 0", alarm_min);
    end
  endtask

  task automatic test_alarm_ring();
    int nh, nm;
    for (int i = 0; i < 30; i++) press(0, 1, nh, nm);
    for (int i = 0; i < 4; i++) press(1, 0, nh, nm);
    for (int i = 0; i < 7; i++) press(0, 1, nh, nm);
    press(1, 0, nh, nm);
    press(1, 0, nh, nm);
    press(0, 1, nh, nm);
    checks++;
    if (mode !== 3'd0 || alarm_hour !== 5'd7 || alarm_min !== 6'd30 || alarm_en !== 1'b1) begin
      failures++;
      $display("FAIL alarm_setup: mode=%0d alarm=%0d:%0d en=%0b, want 0 7:30 1", mode, alarm_hour, alarm_min, alarm_en);
    end
    cur_hour = 5'd7; cur_min = 6'd29; cur_sec = 6'd59;
    step();
    cur_min = 6'd30; cur_sec = 6'd0;
    step();
    checks++;
    if (mode !== 3'd5 || beep_en !== 1'b1 || hold !== 1'b0) begin
      failures++;
      $display("FAIL ring_enter: mode=%0d beep=%0b hold=%0b, want 5 1 0", mode, beep_en, hold);
    end
    for (int k = 1; k <= 30; k++) begin
      tick_pulse();
      step();
      if (k == 29) begin
        checks++;
        if (mode !== 3'd5 || beep_en !== 1'b1) begin
          failures++;
          $display("FAIL ring_29_ticks: mode=%0d beep=%0b, want 5 1", mode, beep_en);
        end
      end
    end
    checks++;
    if (mode !== 3'd0 || beep_en !== 1'b0 || alarm_en !== 1'b1) begin
      failures++;
      $display("FAIL ring_timeout: mode=%0d beep=%0b en=%0b, want 0 0 1", mode, beep_en, alarm_en);
    end
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (mode !== 3'd0 || beep_en !== 1'b0) begin
      failures++;
      $display("FAIL no_rering: mode=%0d beep=%0b, want 0 0", mode, beep_en);
    end
  endtask

  task automatic test_ring_cancel();
    cur_sec = 6'd1;
    step();
    cur_sec = 6'd0;
    step();
    checks++;
    if (mode !== 3'd5) begin
      failures++;
      $display("FAIL ring_reenter: mode=%0d, want 5", mode);
    end
    btn_inc = 1'b1;
    step(); step();
    checks++;
    if (mode !== 3'd0 || beep_en !== 1'b0 || alarm_en !== 1'b1) begin
      failures++;
      $display("FAIL ring_cancel: mode=%0d beep=%0b en=%0b, want 0 0 1", mode, beep_en, alarm_en);
    end
    btn_inc = 1'b0;
    step(); step(); step();
    checks++;
    if (mode !== 3'd0 || alarm_en !== 1'b1) begin
      failures++;
      $display("FAIL ring_cancel_consumed: mode=%0d en=%0b, want 0 1", mode, alarm_en);
    end
  endtask

  task automatic test_reset_mid_ring();
    cur_sec = 6'd1;
    step();
    cur_sec = 6'd0;
    step();
    checks++;
    if (mode !== 3'd5 || beep_en !== 1'b1) begin
      failures++;
      $display("FAIL ring_before_reset: mode=%0d beep=%0b, want 5 1", mode, beep_en);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (beep_en !== 1'b0 || mode !== 3'd0 || alarm_hour !== 5'd0 || alarm_min !== 6'd0 || alarm_en !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: beep=%0b mode=%0d alarm=%0d:%0d en=%0b, want all 0",
               beep_en, mode, alarm_hour, alarm_min, alarm_en);
    end
    rst = 1'b0;
    step(); step();
    checks++;
    if (mode !== 3'd0 || beep_en !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: mode=%0d beep=%0b, want 0 0", mode, beep_en);
    end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_set_min();
    test_blink();
    test_alarm_wrap();
    test_alarm_ring();
    test_ring_cancel();
    test_reset_mid_ring();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
